// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: ALU/LSU writeback requests and register-file write ports
interface regfile_wb_arbiter_if;
  logic alu_wr_valid;
  logic alu_wr_ready;
  logic [9:0] alu_wr_addr;
  logic [31:0] alu_wr_data;
  logic lsu_wr_valid;
  logic lsu_wr_ready;
  logic [9:0] lsu_wr_addr;
  logic [3:0] lsu_wr_mask;
  logic [127:0] lsu_wr_data;
  logic wr0_en;
  logic [9:0] wr0_addr;
  logic [31:0] wr0_data;
  logic [3:0] wr1_en;
  logic [9:0] wr1_addr;
  logic [127:0] wr1_data;
  logic bad_mask;
  logic idle;
  logic [15:0] stall_cnt;
  modport master (
    output alu_wr_valid, alu_wr_addr, alu_wr_data,
    output lsu_wr_valid, lsu_wr_addr, lsu_wr_mask, lsu_wr_data,
    input alu_wr_ready, lsu_wr_ready,
    input wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
    input bad_mask, idle, stall_cnt
  );
  modport slave (
    input alu_wr_valid, alu_wr_addr, alu_wr_data,
    input lsu_wr_valid, lsu_wr_addr, lsu_wr_mask, lsu_wr_data,
    output alu_wr_ready, lsu_wr_ready,
    output wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
    output bad_mask, idle, stall_cnt
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: age-ordered ALU/LSU writeback arbiter; define WB_STALL_CNT_EN for the overlap-stall counter
module regfile_wb_arbiter #(
  parameter int ALU_DEPTH = 2,
  parameter int LSU_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  regfile_wb_arbiter_if.slave bus
);
  localparam logic [2:0] AD = 3'(ALU_DEPTH);
  localparam logic [2:0] LD = 3'(LSU_DEPTH);
  localparam logic [1:0] AL = 2'(ALU_DEPTH - 1);
  localparam logic [1:0] LL = 2'(LSU_DEPTH - 1);
  typedef struct packed {
    logic [3:0] tag;
    logic [9:0] addr;
    logic [31:0] data;
  } alu_ent_t;
  typedef struct packed {
    logic [3:0] tag;
    logic [9:0] addr;
    logic [3:0] mask;
    logic [127:0] data;
  } lsu_ent_t;
  alu_ent_t alu_q [4];
  lsu_ent_t lsu_q [4];
  alu_ent_t ah;
  lsu_ent_t lh;
  logic [1:0] a_wp, a_rp, l_wp, l_rp;
  logic [2:0] a_cnt, l_cnt;
  logic [3:0] tag, a_tag, td;
  logic [9:0] diff, span;
  logic bad_q, a_rdy, l_rdy, a_push, l_acc, l_legal, l_push;
  logic a_v, l_v, overlap, l_older, a_pop, l_pop;
  // Acceptance, tagging and head-to-head overlap/age arbitration
  always_comb begin
    a_rdy = !rst && a_cnt != AD;
    l_rdy = !rst && l_cnt != LD;
    a_push = bus.alu_wr_valid && a_rdy;
    l_acc = bus.lsu_wr_valid && l_rdy;
    l_legal = bus.lsu_wr_mask == 4'b0001 || bus.lsu_wr_mask == 4'b0011 || bus.lsu_wr_mask == 4'b1111;
    l_push = l_acc && l_legal;
    a_tag = l_push ? tag + 4'd1 : tag;
    ah = alu_q[a_rp];
    lh = lsu_q[l_rp];
    a_v = a_cnt != 3'd0;
    l_v = l_cnt != 3'd0;
    span = lh.mask == 4'b0001 ? 10'd1 : lh.mask == 4'b0011 ? 10'd2 : 10'd4;
    diff = ah.addr - lh.addr;
    td = ah.tag - lh.tag;
    l_older = td != 4'd0 && !td[3];
    overlap = a_v && l_v && diff < span;
    a_pop = a_v && !(overlap && l_older);
    l_pop = l_v && !(overlap && !l_older);
  end
  // ALU FIFO: entries carry their arrival tag for the age compare
  always_ff @(posedge clk) begin
    if (rst) begin
      a_wp <= 2'd0;
      a_rp <= 2'd0;
      a_cnt <= 3'd0;
    end else begin
      if (a_push) begin
        alu_q[a_wp] <= '{tag: a_tag, addr: bus.alu_wr_addr, data: bus.alu_wr_data};
        a_wp <= a_wp == AL ? 2'd0 : a_wp + 2'd1;
      end
      if (a_pop) a_rp <= a_rp == AL ? 2'd0 : a_rp + 2'd1;
      a_cnt <= a_cnt + {2'b0, a_push} - {2'b0, a_pop};
    end
  end
  // LSU FIFO: illegal masks are accepted but never enqueued
  always_ff @(posedge clk) begin
    if (rst) begin
      l_wp <= 2'd0;
      l_rp <= 2'd0;
      l_cnt <= 3'd0;
    end else begin
      if (l_push) begin
        lsu_q[l_wp] <= '{tag: tag, addr: bus.lsu_wr_addr, mask: bus.lsu_wr_mask, data: bus.lsu_wr_data};
        l_wp <= l_wp == LL ? 2'd0 : l_wp + 2'd1;
      end
      if (l_pop) l_rp <= l_rp == LL ? 2'd0 : l_rp + 2'd1;
      l_cnt <= l_cnt + {2'b0, l_push} - {2'b0, l_pop};
    end
  end
  // Wrapping sequence tag and sticky illegal-mask flag
  always_ff @(posedge clk) begin
    if (rst) begin
      tag <= 4'd0;
      bad_q <= 1'b0;
    end else begin
      tag <= tag + {3'b0, a_push} + {3'b0, l_push};
      bad_q <= bad_q || (l_acc && !l_legal);
    end
  end
  assign bus.alu_wr_ready = a_rdy;
  assign bus.lsu_wr_ready = l_rdy;
  assign bus.wr0_en = a_pop && !rst;
  assign bus.wr0_addr = ah.addr;
  assign bus.wr0_data = ah.data;
  assign bus.wr1_en = (l_pop && !rst) ? lh.mask : 4'b0000;
  assign bus.wr1_addr = lh.addr;
  assign bus.wr1_data = lh.data;
  assign bus.bad_mask = bad_q && !rst;
  assign bus.idle = rst || (!a_v && !l_v);
`ifdef WB_STALL_CNT_EN
  logic [15:0] stall_q;
  // Count cycles where an overlapping younger head is held back
  always_ff @(posedge clk) begin
    if (rst) stall_q <= 16'd0;
    else if (overlap && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
  end
  assign bus.stall_cnt = rst ? 16'd0 : stall_q;
`else
  assign bus.stall_cnt = 16'd0;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed scoreboard bench for the writeback arbiter
module tb_regfile_wb_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  regfile_wb_arbiter_if bus();
  regfile_wb_arbiter #(.ALU_DEPTH(2), .LSU_DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  int tests = 0;
  int fails = 0;
  logic [41:0] aq [$];
  logic [141:0] lq [$];
  logic [41:0] ea;
  logic [141:0] el;
  logic acc_a, acc_l;
  int lcnt;
  logic full_seen;
`ifdef WB_STALL_CNT_EN
  localparam logic [15:0] STALL_EXP = 16'd1;
`else
  localparam logic [15:0] STALL_EXP = 16'd0;
`endif
  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask
  function automatic logic legal(input logic [3:0] m);
    return m == 4'b0001 || m == 4'b0011 || m == 4'b1111;
  endfunction
  task automatic alu(input logic [9:0] ad, input logic [31:0] d);
    bus.alu_wr_valid = 1'b1;
    bus.alu_wr_addr = ad;
    bus.alu_wr_data = d;
  endtask
  task automatic lsu(input logic [9:0] ad, input logic [3:0] m, input logic [127:0] d);
    bus.lsu_wr_valid = 1'b1;
    bus.lsu_wr_addr = ad;
    bus.lsu_wr_mask = m;
    bus.lsu_wr_data = d;
  endtask
  task automatic sample();
    @(negedge clk);
    acc_a = bus.alu_wr_valid && bus.alu_wr_ready;
    acc_l = bus.lsu_wr_valid && bus.lsu_wr_ready;
  endtask
  task automatic commit();
    @(posedge clk);
    if (acc_a) aq.push_back({bus.alu_wr_addr, bus.alu_wr_data});
    if (acc_l && legal(bus.lsu_wr_mask)) lq.push_back({bus.lsu_wr_addr, bus.lsu_wr_mask, bus.lsu_wr_data});
    #1;
    bus.alu_wr_valid = 1'b0;
    bus.lsu_wr_valid = 1'b0;
  endtask
  task automatic tick();
    sample();
    commit();
  endtask
  always @(negedge clk) if (!rst) begin
    if (bus.wr0_en) begin
      chk("wr0_expected", aq.size() != 0, 1'b1);
      if (aq.size() != 0) begin
        ea = aq.pop_front();
        chk("wr0_addr", bus.wr0_addr, ea[41:32]);
        chk("wr0_data", bus.wr0_data, ea[31:0]);
      end
    end
    if (bus.wr1_en != 4'b0000) begin
      chk("wr1_expected", lq.size() != 0, 1'b1);
      if (lq.size() != 0) begin
        el = lq.pop_front();
        chk("wr1_addr", bus.wr1_addr, el[141:132]);
        chk("wr1_en", bus.wr1_en, el[131:128]);
        chk("wr1_data", bus.wr1_data, el[127:0]);
      end
    end
  end
  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    bus.alu_wr_valid = 1'b0;
    bus.alu_wr_addr = '0;
    bus.alu_wr_data = '0;
    bus.lsu_wr_valid = 1'b0;
    bus.lsu_wr_addr = '0;
    bus.lsu_wr_mask = '0;
    bus.lsu_wr_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_alu_ready", bus.alu_wr_ready, 1'b0);
    chk("rst_lsu_ready", bus.lsu_wr_ready, 1'b0);
    chk("rst_wr0_en", bus.wr0_en, 1'b0);
    chk("rst_wr1_en", bus.wr1_en, 4'b0000);
    chk("rst_idle", bus.idle, 1'b1);
    chk("rst_bad_mask", bus.bad_mask, 1'b0);
    chk("rst_stall_cnt", bus.stall_cnt, 16'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_alu_ready", bus.alu_wr_ready, 1'b1);
    chk("post_rst_lsu_ready", bus.lsu_wr_ready, 1'b1);
    @(posedge clk); #1;
    alu(10'h005, 32'hA5A5A5A5);
    tick();
    @(negedge clk);
    chk("single_wr0_en", bus.wr0_en, 1'b1);
    chk("single_wr1_en", bus.wr1_en, 4'b0000);
    @(negedge clk);
    chk("single_idle", bus.idle, 1'b1);
    chk("single_wr0_done", bus.wr0_en, 1'b0);
    @(posedge clk); #1;
    alu(10'h010, 32'h11111111);
    lsu(10'h020, 4'b1111, 128'h44444444_33333333_22222222_11112222);
    tick();
    @(negedge clk);
    chk("dual_wr0_en", bus.wr0_en, 1'b1);
    chk("dual_wr1_en", bus.wr1_en, 4'b1111);
    @(negedge clk);
    chk("dual_idle", bus.idle, 1'b1);
    @(posedge clk); #1;
    alu(10'h000, 32'h0BADF00D);
    lsu(10'h3FE, 4'b0011, 128'h0_0_CAFE0002_CAFE0001);
    tick();
    @(negedge clk);
    chk("edge_noovl_wr0_en", bus.wr0_en, 1'b1);
    chk("edge_noovl_wr1_en", bus.wr1_en, 4'b0011);
    @(posedge clk); #1;
    alu(10'h001, 32'h00C0FFEE);
    lsu(10'h3FE, 4'b1111, 128'hD4D4D4D4_D3D3D3D3_D2D2D2D2_D1D1D1D1);
    tick();
    @(negedge clk);
    chk("wrap_lsu_first_wr1", bus.wr1_en, 4'b1111);
    chk("wrap_lsu_first_wr0", bus.wr0_en, 1'b0);
    chk("wrap_stall_before", bus.stall_cnt, 16'd0);
    @(negedge clk);
    chk("wrap_alu_second_wr0", bus.wr0_en, 1'b1);
    chk("wrap_alu_second_wr1", bus.wr1_en, 4'b0000);
    chk("wrap_stall_cnt", bus.stall_cnt, STALL_EXP);
    @(posedge clk); #1;
    lcnt = 0;
    full_seen = 1'b0;
    for (int c = 0; c < 14; c++) begin
      if (c < 9) begin
        alu(10'h100, 32'h1000 + c);
        lsu(10'h100, 4'b0001, 128'h2000 + 128'(c));
      end
      sample();
      chk("lsu_ready_vs_occupancy", bus.lsu_wr_ready, lcnt != 4);
      if (lcnt == 4) full_seen = 1'b1;
      if (bus.wr1_en != 4'b0000) lcnt--;
      if (acc_l) lcnt++;
      commit();
    end
    chk("lsu_fifo_filled", full_seen, 1'b1);
    for (int i = 0; i < 20 && !bus.idle; i++) @(negedge clk);
    chk("drain_idle", bus.idle, 1'b1);
    chk("drain_scoreboard_empty", aq.size() + lq.size(), 0);
    @(posedge clk); #1;
    lsu(10'h050, 4'b0101, 128'hDEAD);
    tick();
    @(negedge clk);
    chk("badmask_no_write", bus.wr1_en, 4'b0000);
    chk("badmask_set", bus.bad_mask, 1'b1);
    chk("badmask_idle", bus.idle, 1'b1);
    @(negedge clk);
    chk("badmask_sticky", bus.bad_mask, 1'b1);
    @(posedge clk); #1;
    alu(10'h200, 32'h77777777);
    lsu(10'h200, 4'b1111, 128'h8888);
    tick();
    rst = 1'b1;
    aq.delete();
    lq.delete();
    @(negedge clk);
    chk("midrst_wr0_en", bus.wr0_en, 1'b0);
    chk("midrst_wr1_en", bus.wr1_en, 4'b0000);
    chk("midrst_idle", bus.idle, 1'b1);
    chk("midrst_bad_mask", bus.bad_mask, 1'b0);
    chk("midrst_lsu_ready", bus.lsu_wr_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("after_rst_idle", bus.idle, 1'b1);
    chk("after_rst_wr0_en", bus.wr0_en, 1'b0);
    chk("after_rst_wr1_en", bus.wr1_en, 4'b0000);
    chk("after_rst_alu_ready", bus.alu_wr_ready, 1'b1);
    chk("after_rst_bad_mask", bus.bad_mask, 1'b0);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
